// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Merges load-use, branch and data-memory handshake events into
//               per-stage write-enable / flush / bubble controls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_stall_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             mem_start_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);

    localparam int c_WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0]    r_stallCnt;
    logic                r_timeout;

    logic w_pcWrite, w_ifIdWrite, w_ifIdFlush, w_idExBubble;
    logic w_exMemWrite, w_memWbWrite, w_memStart;
    logic w_waitClr, w_setTimeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_waitCnt  <= '0;
            r_stallCnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_waitClr)
                r_waitCnt <= '0;
            else if (r_state == MEM_WAIT)
                r_waitCnt <= r_waitCnt + c_WAIT_W'(1);
            if (!w_pcWrite && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if (w_setTimeout)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_pcWrite    = 1'b0;
        w_ifIdWrite  = 1'b0;
        w_ifIdFlush  = 1'b0;
        w_idExBubble = 1'b0;
        w_exMemWrite = 1'b0;
        w_memWbWrite = 1'b0;
        w_memStart   = 1'b0;
        w_waitClr    = 1'b0;
        w_setTimeout = 1'b0;
        case (r_state)
            RUN, MEM_DONE: begin
                // MEM_DONE ignores mem_req_i so the finished access is not relaunched
                if ((r_state == RUN) && mem_req_i) begin
                    w_memStart  = 1'b1;
                    w_waitClr   = 1'b1;
                    w_nextState = MEM_WAIT;
                end else begin
                    w_pcWrite    = 1'b1;
                    w_ifIdWrite  = 1'b1;
                    w_exMemWrite = 1'b1;
                    w_memWbWrite = 1'b1;
                    // Load-use beats branch: the branch operand is not ready yet
                    if (hazard_stall_i) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdWrite  = 1'b0;
                        w_idExBubble = 1'b1;
                    end else if (branch_taken_i) begin
                        w_ifIdFlush = 1'b1;
                    end
                    if (r_state == MEM_DONE)
                        w_nextState = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    w_nextState = MEM_DONE;
                end else if (r_waitCnt == c_WAIT_MAX) begin
                    w_nextState  = ERROR;
                    w_setTimeout = 1'b1;
                end
            end
            ERROR: begin
                w_nextState = ERROR;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    assign pc_write_o     = w_pcWrite    & ~rst_i;
    assign if_id_write_o  = w_ifIdWrite  & ~rst_i;
    assign if_id_flush_o  = w_ifIdFlush  & ~rst_i;
    assign id_ex_bubble_o = w_idExBubble & ~rst_i;
    assign ex_mem_write_o = w_exMemWrite & ~rst_i;
    assign mem_wb_write_o = w_memWbWrite & ~rst_i;
    assign mem_start_o    = w_memStart   & ~rst_i;
    assign stall_cnt_o    = r_stallCnt;
    assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Scoreboard bench for pipeline_stall_controller (TIMEOUT_CYC=8, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    localparam int c_TO    = 8;
    localparam int c_CNT_W = 4;
    localparam int MS_RUN  = 0;
    localparam int MS_WAIT = 1;
    localparam int MS_DONE = 2;
    localparam int MS_ERR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hz = 1'b0, br = 1'b0, mreq = 1'b0, mack = 1'b0;
    logic pcW, ifIdW, ifIdF, idExB, exMemW, memWbW, mStart, tOut;
    logic [c_CNT_W-1:0] sCnt;

    typedef struct {
        string               tag;
        logic [7:0]          ctl;
        logic [c_CNT_W-1:0]  cnt;
    } exp_t;
    exp_t sb[$];

    int nChecks = 0;
    int nPass   = 0;

    int mState = MS_RUN;
    int mWait  = 0;
    int mCnt   = 0;
    bit mTo    = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.TIMEOUT_CYC(c_TO), .CNT_W(c_CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .hazard_stall_i(hz), .branch_taken_i(br),
        .mem_req_i(mreq), .mem_ack_i(mack),
        .pc_write_o(pcW), .if_id_write_o(ifIdW), .if_id_flush_o(ifIdF),
        .id_ex_bubble_o(idExB), .ex_mem_write_o(exMemW), .mem_wb_write_o(memWbW),
        .mem_start_o(mStart), .stall_cnt_o(sCnt), .timeout_o(tOut)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic modelReset();
        mState = MS_RUN; mWait = 0; mCnt = 0; mTo = 1'b0;
    endtask

    // Bit order: pc, ifid, flush, bubble, exmem, memwb, start, timeout
    function automatic logic [7:0] modelCtl(input logic h, input logic b, input logic r, input logic rs);
        logic [7:0] v;
        v = 8'h00;
        if (!rs) begin
            if (mState == MS_RUN && r)                  v = 8'b0000_0010;
            else if (mState == MS_RUN || mState == MS_DONE) begin
                if (h)      v = 8'b0001_1100;
                else if (b) v = 8'b1110_1100;
                else        v = 8'b1100_1100;
            end
            else if (mState == MS_WAIT)                 v = {7'b0, mTo};
            else                                        v = 8'b0000_0001;
        end
        return v;
    endfunction

    task automatic modelAdvance(input logic r, input logic a, input logic rs, input logic [7:0] ctl);
        if (rs) begin
            modelReset();
        end else begin
            if (!ctl[7] && mCnt < 15) mCnt++;
            case (mState)
                MS_RUN:  if (r) begin mState = MS_WAIT; mWait = 0; end
                MS_WAIT: begin
                    if (a) mState = MS_DONE;
                    else if (mWait == c_TO - 1) begin mState = MS_ERR; mTo = 1'b1; end
                    else mWait++;
                end
                MS_DONE: mState = MS_RUN;
                default: mState = MS_ERR;
            endcase
        end
    endtask

    task automatic cycle(input logic h, input logic b, input logic r, input logic a,
                         input logic rs, input string tag);
        exp_t e;
        logic [7:0] got;
        @(negedge clk);
        hz = h; br = b; mreq = r; mack = a; rst = rs;
        if (rs) modelReset();
        e.tag = tag;
        e.ctl = modelCtl(h, b, r, rs);
        e.cnt = c_CNT_W'(mCnt);
        sb.push_back(e);
        #1;
        e   = sb.pop_front();
        got = {pcW, ifIdW, ifIdF, idExB, exMemW, memWbW, mStart, tOut};
        checkEq({e.tag, "_ctl"}, 32'(got), 32'(e.ctl));
        checkEq({e.tag, "_cnt"}, 32'(sCnt), 32'(e.cnt));
        @(posedge clk);
        modelAdvance(r, a, rs, e.ctl);
    endtask

    initial begin
        // Reset held, then released
        cycle(0, 0, 0, 0, 1, "rst0");
        cycle(1, 1, 1, 0, 1, "rst1");
        cycle(0, 0, 0, 0, 0, "idle");

        // Load-use, branch alone, load-use plus branch
        cycle(1, 0, 0, 0, 0, "loaduse");
        #1 checkEq("lu_cnt", 32'(sCnt), 32'd1);
        cycle(0, 1, 0, 0, 0, "branch");
        cycle(1, 1, 0, 0, 0, "lu_br");
        cycle(0, 0, 0, 0, 0, "idle2");

        // Memory access acked 5 cycles after start
        cycle(0, 0, 0, 0, 1, "rstm");
        cycle(0, 0, 1, 0, 0, "mstart");
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, "mwait");
        cycle(0, 0, 1, 1, 0, "mack");
        cycle(0, 0, 1, 0, 0, "mdone");
        #1 checkEq("mem_cnt", 32'(sCnt), 32'd6);
        cycle(0, 0, 0, 0, 0, "mrun");

        // Branch held through a freeze
        cycle(0, 0, 0, 0, 1, "rstb");
        cycle(0, 1, 1, 0, 0, "bstart");
        cycle(0, 1, 1, 0, 0, "bwait");
        cycle(0, 1, 1, 1, 0, "back");
        cycle(0, 1, 1, 0, 0, "bdone");
        cycle(0, 0, 0, 0, 0, "brun");

        // Never acked: timeout into ERROR, ack there is ignored
        cycle(0, 0, 0, 0, 1, "rstt");
        cycle(0, 0, 1, 0, 0, "tstart");
        for (int i = 0; i < c_TO; i++) cycle(0, 0, 1, 0, 0, "twait");
        cycle(0, 0, 1, 1, 0, "terr_ack");
        cycle(1, 1, 0, 0, 0, "terr");
        cycle(0, 0, 0, 0, 0, "terr2");
        #1 checkEq("to_flag", 32'(tOut), 32'd1);
        cycle(0, 0, 0, 0, 1, "trst");
        cycle(0, 0, 0, 0, 0, "trun");
        #1 checkEq("to_clr", 32'(tOut), 32'd0);

        // Counter saturation
        cycle(0, 0, 0, 0, 1, "rsts");
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0, "sat");
        #1 checkEq("sat_cnt", 32'(sCnt), 32'd15);

        // Asynchronous reset between edges during MEM_WAIT
        cycle(0, 0, 0, 0, 1, "rsta");
        cycle(0, 0, 1, 0, 0, "astart");
        cycle(0, 0, 1, 0, 0, "await");
        cycle(0, 0, 1, 0, 0, "await");
        @(negedge clk);
        #1 checkEq("async_pre_cnt", 32'(sCnt), 32'd3);
        #1 rst = 1'b1;
        #1 checkEq("async_cnt", 32'(sCnt), 32'd0);
        checkEq("async_ctl", 32'({pcW, ifIdW, ifIdF, idExB, exMemW, memWbW, mStart, tOut}), 32'd0);
        mreq = 1'b0;
        #1 rst = 1'b0;
        modelReset();
        #0.5 checkEq("async_run_pc", 32'(pcW), 32'd1);
        cycle(0, 0, 0, 0, 0, "arun");
        cycle(0, 0, 0, 0, 0, "arun2");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
